sim_step_ctrl: RTL and testbench
================================

SIM_STEP_CTRL -- requirements
Module: sim_step_ctrl

Interface
REQ-001 SHALL have parameter RESET_HOLD, default 50, number of cycles dut_reset is held after controller reset release.
REQ-002 SHALL have parameter CNT_W, default 64, width of cycle counter and max_cycles.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port max_cycles  input  CNT_W  run-cycle limit; 0 = unlimited; sampled every cycle.
REQ-006 SHALL have port dut_reset  output  1  active-high reset to simulated top.
REQ-007 SHALL have port dut_clk_en  output  1  clock enable to simulated top; 1 = DUT advances.
REQ-008 SHALL have port step_valid  input  1  commit-step indication from DUT difftest.
REQ-009 SHALL have port uart_valid  input  1  DUT UART output strobe.
REQ-010 SHALL have port uart_ch  input  8  DUT UART output character.
REQ-011 SHALL have port init_req / init_ack  output / input  1 / 1  checker-init handshake.
REQ-012 SHALL have port step_req / step_ack / step_err  output / input / input  1 / 1 / 1  checker-step handshake; step_err qualified by step_ack.
REQ-013 SHALL have port char_valid / char_data  output / output  1 / 8  forwarded printable console character.
REQ-014 SHALL have port finish / exit_code  output / output  1 / 2  end-of-run flag; code 0 none, 1 good trap, 2 step error, 3 max cycles.
REQ-015 SHALL have port cycle_cnt  output  CNT_W  count of RUN cycles with dut_clk_en=1.

Function
REQ-016 SHALL implement states HOLD, INIT, RUN, STEP_WAIT, DONE.
REQ-017 HOLD: dut_reset=1, dut_clk_en=1, hold counter increments; after exactly RESET_HOLD HOLD cycles -> INIT.
REQ-018 INIT: dut_reset=0, dut_clk_en=0, init_req=1 until cycle init_ack=1 sampled; then -> RUN; init_req deasserts next cycle.
REQ-019 RUN: dut_clk_en=1; cycle_cnt increments by 1 each RUN cycle, saturating at all-ones.
REQ-020 RUN, uart_valid=1, uart_ch[7]=0: char_valid=1 and char_data=uart_ch on next cycle, for one cycle.
REQ-021 RUN, uart_valid=1, uart_ch[7]=1: -> DONE, exit_code=1; no char forwarded.
REQ-022 RUN, step_valid=1: -> STEP_WAIT; step_req=1 and dut_clk_en=0 throughout STEP_WAIT.
REQ-023 STEP_WAIT: on step_ack=1 with step_err=0 -> RUN; with step_err=1 -> DONE, exit_code=2.
REQ-024 RUN, max_cycles!=0 and cycle_cnt+1 == max_cycles in that cycle: -> DONE, exit_code=3 after the increment.
REQ-025 Same-cycle priority in RUN: good trap > step_valid > max-cycles; printable char forwarded regardless of step/max-cycle event.
REQ-026 DONE: finish=1, dut_clk_en=0, step_req=0, init_req=0, exit_code and cycle_cnt frozen; remain until reset.
REQ-027 init_ack outside INIT and step_ack outside STEP_WAIT SHALL be ignored.
REQ-028 step_valid, uart_valid SHALL be ignored in HOLD, INIT, STEP_WAIT, DONE.
REQ-029 All outputs SHALL be registered; no combinational path input -> output.

Reset
REQ-030 reset=0 sampled SHALL force HOLD, hold counter 0, cycle_cnt 0, dut_reset=1, dut_clk_en=1, init_req=0, step_req=0, char_valid=0, char_data=0, finish=0, exit_code=0, from any state including mid-handshake.
REQ-031 After reset release a pending ack from a prior run SHALL have no effect until the matching state is re-entered.

Verification
REQ-032 RESET_HOLD=50, reset low 3 cycles then high -> dut_reset=1 exactly 50 cycles, then init_req=1; init_ack after 7 cycles -> RUN, dut_clk_en=1.
REQ-033 RUN, step_valid pulse; step_ack after 4 cycles, step_err=0 -> dut_clk_en=0 for those cycles, cycle_cnt unchanged, back to RUN.
REQ-034 RUN, uart_ch=0x41 then 0x80 -> char_valid once with 0x41, then finish=1, exit_code=1.
REQ-035 max_cycles=100, no events -> finish=1, exit_code=3, cycle_cnt=100; max_cycles=0 -> no finish after 10000 cycles.
REQ-036 Same cycle uart_ch=0x80 and step_valid -> exit_code=1, step_req never asserted; step_ack with step_err=1 -> exit_code=2.
REQ-037 reset asserted during STEP_WAIT -> next cycle HOLD, step_req=0, finish=0, cycle_cnt=0.

Source files
------------

// File: rtl/sim_step_ctrl_if.sv
// Handshake bundle between the step controller, the simulated DUT and the difftest checker.
interface sim_step_ctrl_if;
    logic       dut_reset;
    logic       dut_clk_en;
    logic       step_valid;
    logic       uart_valid;
    logic [7:0] uart_ch;
    logic       init_req;
    logic       init_ack;
    logic       step_req;
    logic       step_ack;
    logic       step_err;
    logic       char_valid;
    logic [7:0] char_data;

    modport master (
        output dut_reset, dut_clk_en, init_req, step_req, char_valid, char_data,
        input  step_valid, uart_valid, uart_ch, init_ack, step_ack, step_err
    );

    modport slave (
        input  dut_reset, dut_clk_en, init_req, step_req, char_valid, char_data,
        output step_valid, uart_valid, uart_ch, init_ack, step_ack, step_err
    );
endinterface

// File: rtl/sim_step_ctrl.sv
// Simulation step controller: holds the DUT in reset, runs the checker init handshake,
// then advances the DUT one commit at a time against the checker until a run-ending event.
module sim_step_ctrl #(
    parameter int unsigned RESET_HOLD = 50,
    parameter int unsigned CNT_W      = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CNT_W-1:0]  max_cycles,
    sim_step_ctrl_if.master   bus,
    output logic              finish,
    output logic [1:0]        exit_code,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam logic [2:0] S_HOLD      = 3'd0;
    localparam logic [2:0] S_INIT      = 3'd1;
    localparam logic [2:0] S_RUN       = 3'd2;
    localparam logic [2:0] S_STEP_WAIT = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    localparam logic [1:0] EXIT_NONE = 2'd0;
    localparam logic [1:0] EXIT_TRAP = 2'd1;
    localparam logic [1:0] EXIT_STEP = 2'd2;
    localparam logic [1:0] EXIT_MAX  = 2'd3;

    localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    logic [2:0]        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [1:0]        exit_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W:0]    cnt_plus;
    logic              max_hit;
    logic              char_valid_nxt;
    logic [7:0]        char_data_nxt;

    // Widened increment so the max-cycles compare cannot alias on counter wrap.
    assign cnt_plus = {1'b0, cycle_cnt} + (CNT_W+1)'(1);
    assign max_hit  = (max_cycles != '0) && (cnt_plus == {1'b0, max_cycles});

    always_comb begin
        state_nxt      = state;
        hold_nxt       = hold_cnt;
        exit_nxt       = exit_code;
        cnt_nxt        = cycle_cnt;
        char_valid_nxt = 1'b0;
        char_data_nxt  = bus.char_data;
        case (state)
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = S_INIT;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            S_INIT: begin
                if (bus.init_ack)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                cnt_nxt = (cycle_cnt == '1) ? cycle_cnt : cnt_plus[CNT_W-1:0];
                if (bus.uart_valid && !bus.uart_ch[7]) begin
                    char_valid_nxt = 1'b1;
                    char_data_nxt  = bus.uart_ch;
                end
                // Good trap wins over a same-cycle commit, which wins over the cycle limit.
                if (bus.uart_valid && bus.uart_ch[7]) begin
                    state_nxt = S_DONE;
                    exit_nxt  = EXIT_TRAP;
                end else if (bus.step_valid) begin
                    state_nxt = S_STEP_WAIT;
                end else if (max_hit) begin
                    state_nxt = S_DONE;
                    exit_nxt  = EXIT_MAX;
                end
            end
            S_STEP_WAIT: begin
                if (bus.step_ack) begin
                    if (bus.step_err) begin
                        state_nxt = S_DONE;
                        exit_nxt  = EXIT_STEP;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_HOLD;
                hold_nxt  = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so every one of them comes straight off a flop.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= S_HOLD;
            hold_cnt       <= '0;
            cycle_cnt      <= '0;
            exit_code      <= EXIT_NONE;
            finish         <= 1'b0;
            bus.dut_reset  <= 1'b1;
            bus.dut_clk_en <= 1'b1;
            bus.init_req   <= 1'b0;
            bus.step_req   <= 1'b0;
            bus.char_valid <= 1'b0;
            bus.char_data  <= '0;
        end else begin
            state          <= state_nxt;
            hold_cnt       <= hold_nxt;
            cycle_cnt      <= cnt_nxt;
            exit_code      <= exit_nxt;
            finish         <= (state_nxt == S_DONE);
            bus.dut_reset  <= (state_nxt == S_HOLD);
            bus.dut_clk_en <= (state_nxt == S_HOLD) || (state_nxt == S_RUN);
            bus.init_req   <= (state_nxt == S_INIT);
            bus.step_req   <= (state_nxt == S_STEP_WAIT);
            bus.char_valid <= char_valid_nxt;
            bus.char_data  <= char_data_nxt;
        end
    end

endmodule

// File: tb/tb_sim_step_ctrl.sv
// Directed and randomized checks of sim_step_ctrl against a cycle-level behavioural model.
module tb_sim_step_ctrl;

    logic        clock;
    logic        reset;
    logic [63:0] max_cycles;
    logic        finish;
    logic [1:0]  exit_code;
    logic [63:0] cycle_cnt;

    logic        finish2;
    logic [1:0]  exit_code2;
    logic [3:0]  cycle_cnt2;

    int n_vec = 0;
    int n_err = 0;

    sim_step_ctrl_if bus();
    sim_step_ctrl_if bus2();

    sim_step_ctrl #(.RESET_HOLD(50), .CNT_W(64)) dut (
        .clock(clock), .reset(reset), .max_cycles(max_cycles), .bus(bus),
        .finish(finish), .exit_code(exit_code), .cycle_cnt(cycle_cnt)
    );

    // Narrow-counter instance that free-runs to check counter saturation.
    sim_step_ctrl #(.RESET_HOLD(2), .CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .max_cycles(4'd0), .bus(bus2),
        .finish(finish2), .exit_code(exit_code2), .cycle_cnt(cycle_cnt2)
    );

    assign bus2.step_valid = 1'b0;
    assign bus2.uart_valid = 1'b0;
    assign bus2.uart_ch    = 8'h00;
    assign bus2.init_ack   = 1'b1;
    assign bus2.step_ack   = 1'b0;
    assign bus2.step_err   = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.step_valid = 1'b0;
        bus.uart_valid = 1'b0;
        bus.uart_ch    = 8'h00;
        bus.init_ack   = 1'b0;
        bus.step_ack   = 1'b0;
        bus.step_err   = 1'b0;
    endtask

    task automatic reset_to_run();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        repeat (50) tick();
        bus.init_ack = 1'b1;
        tick();
        bus.init_ack = 1'b0;
        check("run_entry", {bus.dut_clk_en, bus.init_req, bus.dut_reset}, 3'b100);
    endtask

    // Behavioural reference: 0 = DUT running, 1 = stalled awaiting checker, 2 = finished.
    int          m_mode;
    longint      m_cnt;
    logic [1:0]  m_code;
    logic        exp_cv;
    logic [7:0]  exp_cd;

    initial begin
        int   n;
        logic saw_finish;
        logic sv, uv, ack, err;
        logic [7:0] ch;

        reset      = 1'b0;
        max_cycles = '0;
        clear_inputs();
        repeat (3) tick();
        check("rst_dut_reset", bus.dut_reset, 1'b1);
        check("rst_clk_en", bus.dut_clk_en, 1'b1);
        check("rst_reqs", {bus.init_req, bus.step_req}, 2'b00);
        check("rst_char", {bus.char_valid, bus.char_data}, 9'h000);
        check("rst_finish", {finish, exit_code}, 3'b000);
        check("rst_cnt", cycle_cnt, 64'd0);

        // Release reset with stray events that HOLD must ignore.
        reset          = 1'b1;
        bus.step_ack   = 1'b1;
        bus.step_valid = 1'b1;
        bus.uart_valid = 1'b1;
        bus.uart_ch    = 8'h80;
        n = 0;
        while (bus.dut_reset === 1'b1 && n < 200) begin
            bus.init_ack = (n < 40);
            n++;
            tick();
        end
        clear_inputs();
        check("hold_len", 64'(n), 64'd50);
        check("init_enter", {bus.init_req, bus.dut_clk_en, finish}, 3'b100);
        repeat (6) tick();
        check("init_wait", {bus.init_req, bus.dut_clk_en}, 2'b10);
        bus.init_ack = 1'b1;
        tick();
        bus.init_ack = 1'b0;
        check("init_done", {bus.dut_clk_en, bus.init_req}, 2'b10);
        check("init_cnt", cycle_cnt, 64'd0);
        check("sat_cnt", 64'(cycle_cnt2), 64'd15);
        check("sat_finish", {finish2, bus2.dut_clk_en}, 2'b01);

        // Commit step with a 4-cycle checker latency.
        repeat (3) tick();
        check("run_cnt", cycle_cnt, 64'd3);
        bus.step_valid = 1'b1;
        tick();
        bus.step_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall", {bus.step_req, bus.dut_clk_en}, 2'b10);
            check("stall_cnt", cycle_cnt, 64'd4);
            tick();
        end
        bus.step_ack = 1'b1;
        tick();
        bus.step_ack = 1'b0;
        check("step_back", {bus.step_req, bus.dut_clk_en, finish}, 3'b010);
        check("step_cnt", cycle_cnt, 64'd4);

        // Printable char then good trap.
        bus.uart_valid = 1'b1;
        bus.uart_ch    = 8'h41;
        tick();
        check("char_fwd", {bus.char_valid, bus.char_data}, 9'h141);
        bus.uart_ch = 8'h80;
        tick();
        bus.uart_valid = 1'b0;
        check("trap_nochar", bus.char_valid, 1'b0);
        check("trap_exit", {finish, exit_code}, 3'b101);
        bus.step_valid = 1'b1;
        bus.init_ack   = 1'b1;
        repeat (4) tick();
        clear_inputs();
        check("done_frozen", {finish, exit_code, bus.dut_clk_en, bus.step_req, bus.init_req}, 6'b101000);
        check("done_cnt", cycle_cnt, 64'd6);

        // Cycle limit.
        max_cycles = 64'd100;
        reset_to_run();
        n = 0;
        while (finish !== 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check("max_ticks", 64'(n), 64'd100);
        check("max_exit", {finish, exit_code}, 3'b111);
        check("max_cnt", cycle_cnt, 64'd100);

        max_cycles = 64'd0;
        reset_to_run();
        saw_finish = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (finish) saw_finish = 1'b1;
        end
        check("unlimited", saw_finish, 1'b0);
        check("unlimited_cnt", cycle_cnt, 64'd10000);

        // Trap beats a same-cycle commit; then a failing step.
        reset_to_run();
        bus.uart_valid = 1'b1;
        bus.uart_ch    = 8'h80;
        bus.step_valid = 1'b1;
        tick();
        clear_inputs();
        saw_finish = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.step_req) saw_finish = 1'b1;
            tick();
        end
        check("prio_exit", {finish, exit_code}, 3'b101);
        check("prio_noreq", saw_finish, 1'b0);

        reset_to_run();
        bus.step_valid = 1'b1;
        tick();
        bus.step_valid = 1'b0;
        bus.step_ack   = 1'b1;
        bus.step_err   = 1'b1;
        tick();
        clear_inputs();
        check("step_err", {finish, exit_code, bus.dut_clk_en}, 4'b1100);

        // Reset mid-handshake, with a stale ack held across release.
        reset_to_run();
        bus.step_valid = 1'b1;
        tick();
        bus.step_valid = 1'b0;
        bus.step_ack   = 1'b1;
        reset = 1'b0;
        tick();
        check("midrst", {bus.step_req, finish, bus.dut_reset, bus.dut_clk_en}, 4'b0011);
        check("midrst_cnt", cycle_cnt, 64'd0);
        reset = 1'b1;
        repeat (50) tick();
        check("stale_ack", {bus.init_req, finish, bus.step_req}, 3'b100);
        clear_inputs();

        // Randomized runs against the reference model.
        for (int r = 0; r < 6; r++) begin
            max_cycles = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(20, 120));
            reset_to_run();
            m_mode = 0;
            m_cnt  = 0;
            m_code = 2'd0;
            exp_cd = 8'h00;
            n = 0;
            for (int c = 0; c < 400 && n < 4; c++) begin
                sv  = ($urandom_range(0, 9) == 0);
                uv  = ($urandom_range(0, 6) == 0);
                ch  = 8'($urandom_range(0, 127));
                if ($urandom_range(0, 29) == 0) ch[7] = 1'b1;
                ack = ($urandom_range(0, 2) == 0);
                err = ($urandom_range(0, 9) == 0);
                bus.step_valid = sv;
                bus.uart_valid = uv;
                bus.uart_ch    = ch;
                bus.step_ack   = ack;
                bus.step_err   = err;
                tick();
                exp_cv = 1'b0;
                if (m_mode == 0) begin
                    m_cnt++;
                    if (uv && !ch[7]) begin
                        exp_cv = 1'b1;
                        exp_cd = ch;
                    end
                    if (uv && ch[7]) begin
                        m_mode = 2;
                        m_code = 2'd1;
                    end else if (sv) begin
                        m_mode = 1;
                    end else if (max_cycles != 0 && m_cnt == longint'(max_cycles)) begin
                        m_mode = 2;
                        m_code = 2'd3;
                    end
                end else if (m_mode == 1 && ack) begin
                    if (err) begin
                        m_mode = 2;
                        m_code = 2'd2;
                    end else begin
                        m_mode = 0;
                    end
                end
                if (m_mode == 2) n++;
                check("rnd_status",
                      {bus.dut_clk_en, bus.step_req, finish, exit_code, bus.char_valid},
                      {m_mode == 0, m_mode == 1, m_mode == 2, m_code, exp_cv});
                check("rnd_cnt", cycle_cnt, 64'(m_cnt));
                if (exp_cv) check("rnd_char", bus.char_data, exp_cd);
            end
            clear_inputs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
